// File: rtl/hs_link_pkg.sv
// Shared definitions for the four-phase inter-board link: FSM encoding,
// control-bit placement above the payload lanes, and the parity helper.
package hs_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Control bits sit directly above the payload: word[LANE+FLAG_OFS], word[LANE+PAR_OFS].
    localparam int FLAG_OFS  = 0;
    localparam int PAR_OFS   = 1;
    localparam int PAR_MAX_W = 64;

    // Parity bit that makes the whole word (body plus this bit) carry an odd number of ones.
    function automatic logic odd_parity(input logic [PAR_MAX_W-1:0] word);
        return ~^word;
    endfunction

endpackage

// File: rtl/hs_frame_sender_if.sv
// Frame-side valid/ready port plus the req/ack link wires of the frame sender.
// Frame side: a frame moves on the clock edge where wire_frame_valid && reg_frame_ready.
interface hs_frame_sender_if #(
    parameter int FRAME_BITS = 1500,
    parameter int LANE       = 4
);
    import hs_link_pkg::*;

    logic                  wire_frame_valid;
    logic [FRAME_BITS-1:0] wire_frame_in;
    logic                  reg_frame_ready;
    logic                  wire_ack;
    logic                  wire_nack;
    logic                  reg_req;
    logic [LANE+1:0]       reg_data_out;
    logic                  reg_frame_done;
    logic                  reg_error;
    state_t                dbg_state;

    modport master (
        input  wire_frame_valid,
        input  wire_frame_in,
        input  wire_ack,
        input  wire_nack,
        output reg_frame_ready,
        output reg_req,
        output reg_data_out,
        output reg_frame_done,
        output reg_error,
        output dbg_state
    );

    modport slave (
        output wire_frame_valid,
        output wire_frame_in,
        output wire_ack,
        output wire_nack,
        input  reg_frame_ready,
        input  reg_req,
        input  reg_data_out,
        input  reg_frame_done,
        input  reg_error,
        input  dbg_state
    );

endinterface

// File: rtl/hs_sync.sv
// Plain flop-chain synchroniser for an asynchronous level into the local clock.
module hs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/hs_frame_sender.sv
// Four-phase frame sender: one header beat (sequence bit) then ceil(FRAME_BITS/LANE)
// data beats, each word carrying a reset flag and odd parity, with bounded NACK retry.
module hs_frame_sender
    import hs_link_pkg::*;
#(
    parameter int FRAME_BITS  = 1500,
    parameter int LANE        = 4,
    parameter int MAX_RETRY   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_sender,
    input  logic               rst,
    hs_frame_sender_if.master  bus
);

    localparam int BEATS  = (FRAME_BITS + LANE - 1) / LANE;
    localparam int PTR_W  = $clog2(BEATS + 1);
    localparam int RC_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int BUF_W  = BEATS * LANE;
    localparam int WORD_W = LANE + 2;

    localparam logic [WORD_W-1:0] RESET_WORD = {1'b0, 1'b1, {LANE{1'b0}}};

    function automatic logic [WORD_W-1:0] make_word(input logic [LANE-1:0] pay, input logic flag);
        logic [WORD_W-1:0] word;
        word                = '0;
        word[LANE-1:0]      = pay;
        word[LANE+FLAG_OFS] = flag;
        word[LANE+PAR_OFS]  = odd_parity(64'({flag, pay}));
        return word;
    endfunction

    logic w_ack_s;
    logic w_nack_s;

    hs_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk (clk_sender),
        .rst (rst),
        .i_d (bus.wire_ack),
        .o_q (w_ack_s)
    );

    hs_sync #(.STAGES(SYNC_STAGES)) u_sync_nack (
        .clk (clk_sender),
        .rst (rst),
        .i_d (bus.wire_nack),
        .o_q (w_nack_s)
    );

    state_t              r_state;
    logic                r_ready;
    logic                r_req;
    logic                r_done;
    logic                r_err;
    logic                r_seq;
    logic                r_rst_flag;
    logic                r_nack_l;
    logic [PTR_W-1:0]    r_beat;
    logic [RC_W-1:0]     r_retry;
    logic [BUF_W-1:0]    r_buf;
    logic [WORD_W-1:0]   r_data;

    logic [BUF_W-1:0]    w_buf_in;
    logic [BUF_W-1:0]    w_buf_shift;
    logic [LANE-1:0]     w_hdr_pay;
    logic [WORD_W-1:0]   w_hdr_word;
    logic [WORD_W-1:0]   w_data_word;
    logic                w_last;
    logic                w_retry_left;

    // Buffer is padded to whole beats so bits past FRAME_BITS read back as 0.
    assign w_buf_in     = BUF_W'(bus.wire_frame_in);
    assign w_hdr_pay    = {{(LANE-1){1'b0}}, r_seq};
    assign w_hdr_word   = make_word(w_hdr_pay, r_rst_flag);
    // r_beat counts the header as beat 0, so it is also the index of the next data beat.
    assign w_buf_shift  = r_buf >> (32'(r_beat) * LANE);
    assign w_data_word  = make_word(w_buf_shift[LANE-1:0], r_rst_flag);
    assign w_last       = (r_beat == PTR_W'(BEATS));
    assign w_retry_left = (r_retry != RC_W'(MAX_RETRY));

    always_ff @(posedge clk_sender or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_seq      <= 1'b0;
            r_rst_flag <= 1'b1;
            r_nack_l   <= 1'b0;
            r_beat     <= '0;
            r_retry    <= '0;
            r_buf      <= '0;
            r_data     <= RESET_WORD;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.wire_frame_valid && r_ready) begin
                        r_buf   <= w_buf_in;
                        r_beat  <= '0;
                        r_retry <= '0;
                        r_ready <= 1'b0;
                        r_data  <= w_hdr_word;
                        r_req   <= 1'b1;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // An ack still high on entry counts as this beat's handshake.
                    if (w_ack_s) begin
                        r_req    <= 1'b0;
                        r_nack_l <= w_nack_s;
                        r_state  <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_ack_s) begin
                        if (r_nack_l && w_retry_left) begin
                            r_retry <= r_retry + 1'b1;
                            r_req   <= 1'b1;
                            r_state <= ST_DRIVE;
                        end else if (r_nack_l) begin
                            r_err   <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if (w_last) begin
                            r_done     <= 1'b1;
                            r_seq      <= ~r_seq;
                            r_rst_flag <= 1'b0;
                            r_ready    <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_beat  <= r_beat + 1'b1;
                            r_retry <= '0;
                            r_data  <= w_data_word;
                            r_req   <= 1'b1;
                            r_state <= ST_DRIVE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reg_frame_ready = r_ready;
    assign bus.reg_req         = r_req;
    assign bus.reg_data_out    = r_data;
    assign bus.reg_frame_done  = r_done;
    assign bus.reg_error       = r_err;
    assign bus.dbg_state       = r_state;

endmodule

// File: tb/tb_hs_frame_sender.sv
// Bench for hs_frame_sender: a frame-level model expands each frame into the expected
// link words and NACK plan, a receiver model replays the plan with random ack delays.
module tb_hs_frame_sender;
    import hs_link_pkg::*;

    localparam int FB    = 10;
    localparam int LN    = 4;
    localparam int MAXR  = 2;
    localparam int SYNC  = 2;
    localparam int BEATS = (FB + LN - 1) / LN;
    localparam int W     = LN + 2;

    logic clk;
    logic rst;

    hs_frame_sender_if #(.FRAME_BITS(FB), .LANE(LN)) bus ();

    hs_frame_sender #(
        .FRAME_BITS  (FB),
        .LANE        (LN),
        .MAX_RETRY   (MAXR),
        .SYNC_STAGES (SYNC)
    ) u_dut (
        .clk_sender (clk),
        .rst        (rst),
        .bus        (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    bit           nack_q[$];
    int           n_chk  = 0;
    int           n_fail = 0;
    logic         m_seq  = 1'b0;
    logic         m_flag = 1'b1;
    int           last_done_cyc = 0;
    int           rx_stall_cnt  = -1;
    bit           rx_stalled    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_word(input logic [LN-1:0] pay, input logic flag);
        logic [W-1:0] w;
        w = {1'b0, flag, pay};
        if ($countones(w) % 2 == 0) w[W-1] = 1'b1;
        return w;
    endfunction

    // Expand one frame into the words the link must carry, given which handshakes NACK.
    task automatic model_frame(input logic [FB-1:0] f, input logic [15:0] mask, output bit done);
        int           hs;
        int           tries;
        int           idx;
        bit           nk;
        logic [LN-1:0] pay;
        logic [W-1:0]  w;
        hs   = 0;
        done = 1'b1;
        for (int b = 0; b <= BEATS && done; b++) begin
            pay = '0;
            if (b == 0) begin
                pay[0] = m_seq;
            end else begin
                for (int j = 0; j < LN; j++) begin
                    idx = (b - 1) * LN + j;
                    if (idx < FB) pay[j] = f[idx];
                end
            end
            w     = exp_word(pay, m_flag);
            tries = 0;
            forever begin
                nk = mask[hs];
                hs++;
                exp_q.push_back(w);
                nack_q.push_back(nk);
                if (!nk) break;
                if (tries == MAXR) begin
                    done = 1'b0;
                    break;
                end
                tries++;
            end
        end
        if (done) begin
            m_seq  = ~m_seq;
            m_flag = 1'b0;
        end
    endtask

    // ---------------- receiver model ----------------
    initial begin : rx
        int d;
        int t;
        bit nk;
        bus.wire_ack  = 1'b0;
        bus.wire_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.reg_req && !bus.wire_ack) begin
                d = $urandom_range(0, 5);
                repeat (d) @(negedge clk);
                if (exp_q.size() == 0) chk("unexpected_word", bus.reg_data_out, '1);
                else                   chk("link_word", bus.reg_data_out, exp_q.pop_front());
                if (rx_stall_cnt == 0) begin
                    rx_stalled = 1'b1;
                    wait (rx_stall_cnt < 0);
                    rx_stalled = 1'b0;
                end else begin
                    if (rx_stall_cnt > 0) rx_stall_cnt--;
                    nk = (nack_q.size() != 0) ? nack_q.pop_front() : 1'b0;
                    bus.wire_ack  = 1'b1;
                    bus.wire_nack = nk;
                    t = 0;
                    while (bus.reg_req && t < 500) begin
                        @(negedge clk);
                        t++;
                    end
                    if (t >= 500) chk("req_release_timeout", bus.reg_req, 1'b0);
                    d = $urandom_range(0, 5);
                    repeat (d) @(negedge clk);
                    bus.wire_ack  = 1'b0;
                    bus.wire_nack = 1'b0;
                end
            end
        end
    end

    // Every driven word is odd parity and holds still while req is high.
    logic         mon_prev_req  = 1'b0;
    logic [W-1:0] mon_prev_data = '0;
    always @(negedge clk) begin
        if (!rst && bus.reg_req) begin
            chk("word_parity_odd", 64'($countones(bus.reg_data_out) % 2), 64'd1);
            if (mon_prev_req) chk("word_stable_under_req", bus.reg_data_out, mon_prev_data);
        end
        mon_prev_req  <= bus.reg_req && !rst;
        mon_prev_data <= bus.reg_data_out;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int t;
        t = 0;
        while (!bus.reg_frame_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_accept", bus.reg_frame_ready, 1'b1);
    endtask

    task automatic run_frame(input logic [FB-1:0] f, input logic [15:0] mask,
                             input bit hold_valid, input bit chained);
        bit exp_done;
        bit seen_done;
        bit seen_err;
        int t;
        model_frame(f, mask, exp_done);
        wait_ready();
        bus.wire_frame_valid = 1'b1;
        bus.wire_frame_in    = f;
        @(posedge clk);
        #1;
        chk("req_at_accept", bus.reg_req, 1'b1);
        chk("ready_low_after_accept", bus.reg_frame_ready, 1'b0);
        if (chained) chk("back_to_back_gap", 64'(cyc - last_done_cyc), 64'd1);
        bus.wire_frame_valid = hold_valid;
        bus.wire_frame_in    = FB'($urandom);
        seen_done = 1'b0;
        seen_err  = 1'b0;
        t = 0;
        while (!seen_done && !seen_err && t < 3000) begin
            @(negedge clk);
            seen_done = bus.reg_frame_done;
            seen_err  = bus.reg_error;
            t++;
        end
        if (seen_done) last_done_cyc = cyc;
        chk("frame_done", seen_done, exp_done);
        chk("frame_error", seen_err, !exp_done);
        chk("ready_at_end", bus.reg_frame_ready, 1'b1);
        chk("req_at_end", bus.reg_req, 1'b0);
        chk("words_consumed", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   bus.reg_req, 1'b0);
        chk({tag, "_ready"}, bus.reg_frame_ready, 1'b1);
        chk({tag, "_data"},  bus.reg_data_out, 6'h10);
        chk({tag, "_done"},  bus.reg_frame_done, 1'b0);
        chk({tag, "_error"}, bus.reg_error, 1'b0);
        chk({tag, "_state"}, bus.dbg_state, ST_IDLE);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        bit d;
        int t;
        bus.wire_frame_valid = 1'b0;
        bus.wire_frame_in    = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: first frame, flag set, seq 0
        model_frame(10'h2A5, 16'h0, d);
        chk("pin1_hdr",  exp_q[0], 6'h10);
        chk("pin1_d0",   exp_q[1], 6'h15);
        chk("pin1_d1",   exp_q[2], 6'h1A);
        chk("pin1_d2",   exp_q[3], 6'h32);
        exp_q.delete();
        nack_q.delete();
        m_seq  = 1'b0;
        m_flag = 1'b1;
        run_frame(10'h2A5, 16'h0, 1'b0, 1'b0);

        // 2: seq 1, flag cleared
        model_frame(10'h3FF, 16'h0, d);
        chk("pin2_hdr", exp_q[0], 6'h01);
        chk("pin2_d0",  exp_q[1], 6'h2F);
        chk("pin2_d2",  exp_q[3], 6'h23);
        exp_q.delete();
        nack_q.delete();
        m_seq = 1'b1;
        run_frame(10'h3FF, 16'h0, 1'b0, 1'b0);

        // 3: one NACK on data beat 1 (handshake 2)
        model_frame(10'h1C3, 16'h0004, d);
        chk("pin3_len",   64'(exp_q.size()), 64'd5);
        chk("pin3_retry", exp_q[3], 6'h2C);
        chk("pin3_last",  exp_q[4], 6'h01);
        exp_q.delete();
        nack_q.delete();
        m_seq = 1'b0;
        run_frame(10'h1C3, 16'h0004, 1'b0, 1'b0);

        // 4: every attempt of the header NACKed -> abort
        model_frame(10'h0AA, 16'h0007, d);
        chk("pin4_len",  64'(exp_q.size()), 64'd3);
        chk("pin4_word", exp_q[2], 6'h01);
        exp_q.delete();
        nack_q.delete();
        run_frame(10'h0AA, 16'h0007, 1'b0, 1'b0);

        // 5: async reset while driving beat 2
        rx_stall_cnt = 2;
        model_frame(10'h155, 16'h0, d);
        chk("pin5_hdr_seq_kept", exp_q[0], 6'h01);
        wait_ready();
        bus.wire_frame_valid = 1'b1;
        bus.wire_frame_in    = 10'h155;
        @(posedge clk);
        #1;
        bus.wire_frame_valid = 1'b0;
        t = 0;
        while (!rx_stalled && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("stall_reached", rx_stalled, 1'b1);
        chk("req_in_drive", bus.reg_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midframe_reset");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        nack_q.delete();
        m_seq        = 1'b0;
        m_flag       = 1'b1;
        rx_stall_cnt = -1;
        repeat (2) @(negedge clk);
        run_frame(10'h0C3, 16'h0, 1'b0, 1'b0);

        // 6: valid held high, frame_in churning, back-to-back frames
        run_frame(10'h0F0, 16'h0, 1'b1, 1'b0);
        run_frame(10'h30C, 16'h0008, 1'b1, 1'b1);
        run_frame(10'h2B1, 16'h0, 1'b1, 1'b1);
        bus.wire_frame_valid = 1'b0;

        repeat (10) @(negedge clk);
        chk("idle_after_all", bus.reg_req, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
